// File: rtl/alu_issue_queue.sv
// Issue queue in front of the cv32e40p ALU: buffers requests in a FIFO, drives the
// head entry onto the ALU pins, and returns each result through a response register.
module alu_issue_queue #(
  parameter int DEPTH     = 4,
  parameter int OP_WIDTH  = 7,
  parameter int TAG_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [OP_WIDTH-1:0]        req_op_i,
  input  logic [31:0]                req_a_i,
  input  logic [31:0]                req_b_i,
  input  logic [31:0]                req_c_i,
  input  logic [1:0]                 req_vec_mode_i,
  input  logic [TAG_WIDTH-1:0]       req_tag_i,
  output logic                       alu_enable_o,
  output logic [OP_WIDTH-1:0]        alu_operator_o,
  output logic [31:0]                alu_operand_a_o,
  output logic [31:0]                alu_operand_b_o,
  output logic [31:0]                alu_operand_c_o,
  output logic [1:0]                 alu_vector_mode_o,
  output logic                       alu_ex_ready_o,
  input  logic [31:0]                alu_result_i,
  input  logic                       alu_cmp_i,
  input  logic                       alu_ready_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [31:0]                rsp_result_o,
  output logic                       rsp_cmp_o,
  output logic [TAG_WIDTH-1:0]       rsp_tag_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       busy_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [OP_WIDTH-1:0]  op;
    logic [31:0]          a;
    logic [31:0]          b;
    logic [31:0]          c;
    logic [1:0]           vec;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    DIV_WAIT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            active;
  logic            sink_ok;
  logic            push;
  logic            pop;

  assign head       = mem[rd_ptr];
  assign active     = (state != IDLE);
  assign sink_ok    = !rsp_valid_o || rsp_ready_i;
  assign req_ready_o = rst_n && (count != CW'(DEPTH));
  assign push       = req_valid_i && req_ready_o;
  // The head only leaves once the ALU is done and the response register can take it.
  assign pop        = active && alu_ready_i && sink_ok;
  assign count_next = count + CW'(push) - CW'(pop);

  assign count_o = count;
  assign busy_o  = (count != '0) || active;

  assign alu_enable_o      = active;
  assign alu_ex_ready_o    = active && sink_ok;
  assign alu_operator_o    = active ? head.op  : '0;
  assign alu_operand_a_o   = active ? head.a   : '0;
  assign alu_operand_b_o   = active ? head.b   : '0;
  assign alu_operand_c_o   = active ? head.c   : '0;
  assign alu_vector_mode_o = active ? head.vec : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: req_op_i, a: req_a_i, b: req_b_i, c: req_c_i,
                       vec: req_vec_mode_i, tag: req_tag_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (count != '0) state_next = EXEC;
      end
      EXEC: begin
        if (!alu_ready_i)  state_next = DIV_WAIT;
        else if (sink_ok)  state_next = (count_next != '0) ? EXEC : IDLE;
      end
      DIV_WAIT: begin
        if (alu_ready_i && sink_ok) state_next = (count_next != '0) ? EXEC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A capture in the same cycle as a consume keeps valid high with the new data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_o  <= 1'b0;
      rsp_result_o <= '0;
      rsp_cmp_o    <= 1'b0;
      rsp_tag_o    <= '0;
    end else if (pop) begin
      rsp_valid_o  <= 1'b1;
      rsp_result_o <= alu_result_i;
      rsp_cmp_o    <= alu_cmp_i;
      rsp_tag_o    <= head.tag;
    end else if (rsp_ready_i) begin
      rsp_valid_o  <= 1'b0;
    end
  end

endmodule
